// File: rtl/onehot_request_conditioner.sv
// Front-end for the 4-to-2 encoder: synchronises and debounces four raw request lines,
// turns each debounced press into a one-hot word and holds it under a valid/ready handshake.
module onehot_request_conditioner #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req_raw,
    input  logic       ready,
    output logic       valid,
    output logic [3:0] onehot,
    output logic       ovf
);

    // state | meaning
    // IDLE  | no word on the output, valid low
    // HOLD  | onehot carries an unconsumed event, valid high
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic [3:0]       sq1_q;
    logic [3:0]       sq2_q;
    logic [3:0]       deb_q;
    logic [3:0]       deb_d;
    logic [3:0]       deb_prev_q;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       rise;

    logic [3:0]       pending_q;
    logic [3:0]       pending_d;
    logic [3:0]       clr_mask;
    logic [3:0]       pick;
    state_t           state_q;
    state_t           state_d;
    logic             valid_q;
    logic             valid_d;
    logic [3:0]       onehot_q;
    logic [3:0]       onehot_d;
    logic             ovf_q;
    logic             ovf_d;

    function automatic logic [3:0] pick_highest(input logic [3:0] p);
        if (p[3])      return 4'b1000;
        else if (p[2]) return 4'b0100;
        else if (p[1]) return 4'b0010;
        else if (p[0]) return 4'b0001;
        else           return 4'b0000;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sq1_q <= '0;
            sq2_q <= '0;
        end else begin
            sq1_q <= req_raw;
            sq2_q <= sq1_q;
        end
    end

    // A line must disagree with its debounced state for DEB_CYCLES consecutive cycles to flip it.
    always_comb begin
        for (int n = 0; n < 4; n++) begin
            deb_d[n] = deb_q[n];
            cnt_d[n] = '0;
            if (sq2_q[n] != deb_q[n]) begin
                if (cnt_q[n] == CNT_LAST) begin
                    deb_d[n] = sq2_q[n];
                end else begin
                    cnt_d[n] = cnt_q[n] + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_q      <= '0;
            deb_prev_q <= '0;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= '0;
            end
        end else begin
            deb_q      <= deb_d;
            deb_prev_q <= deb_q;
            for (int n = 0; n < 4; n++) begin
                cnt_q[n] <= cnt_d[n];
            end
        end
    end

    assign rise = deb_q & ~deb_prev_q;
    assign pick = pick_highest(pending_q);

    always_comb begin
        state_d  = state_q;
        valid_d  = valid_q;
        onehot_d = onehot_q;
        clr_mask = '0;
        case (state_q)
            IDLE: begin
                if (|pending_q) begin
                    onehot_d = pick;
                    clr_mask = pick;
                    valid_d  = 1'b1;
                    state_d  = HOLD;
                end else begin
                    valid_d  = 1'b0;
                    onehot_d = '0;
                end
            end
            HOLD: begin
                if (ready) begin
                    if (|pending_q) begin
                        onehot_d = pick;
                        clr_mask = pick;
                        valid_d  = 1'b1;
                    end else begin
                        valid_d  = 1'b0;
                        onehot_d = '0;
                        state_d  = IDLE;
                    end
                end
            end
            default: begin
                valid_d  = 1'b0;
                onehot_d = '0;
                state_d  = IDLE;
            end
        endcase
        // A new edge landing on the same cycle its pending bit is consumed re-arms it without loss.
        pending_d = (pending_q & ~clr_mask) | rise;
        ovf_d     = ovf_q | (|(rise & pending_q & ~clr_mask));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            valid_q   <= 1'b0;
            onehot_q  <= '0;
            pending_q <= '0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            valid_q   <= valid_d;
            onehot_q  <= onehot_d;
            pending_q <= pending_d;
            ovf_q     <= ovf_d;
        end
    end

    assign valid  = valid_q;
    assign onehot = onehot_q;
    assign ovf    = ovf_q;

endmodule
